mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the 16-bit pipelined processor. It accepts the EX/MEM-latched instruction and sequences the data-memory access, stalling upstream while a multi-cycle access is outstanding. It registers the committed result into the `mw_*` signals and forms the write-back value `write_data`. The processor trace bench taps these outputs directly. The block also holds the sticky halt state and, optionally, the retire and data-cache performance counters.

## Interface
- `DW`, 16, datapath width.
- `RW`, 3, register-index width.
- `CNT_W`, 32, performance-counter width.

- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `xm_valid` in 1: memory-stage slot holds a real instruction.
- `xm_RegWrite`, `xm_MemRead`, `xm_MemWrite`, `xm_halt` in 1 each: decoded controls.
- `xm_writeReg` in RW: destination register.
- `xm_wb_sel` in 2: write-back source; 00 ALU, 01 memory, 10 link, 11 ALU.
- `xm_ALU_Result` in DW: ALU result / memory address.
- `xm_read_data_2` in DW: store data.
- `xm_link` in DW: PC+2 for JAL/JALR.
- `dmem_en` out 1: data-memory request strobe.
- `dmem_wr` out 1: request is a write.
- `dmem_rdata` in DW: load data.
- `dmem_done` in 1: access completes this cycle.
- `dmem_hit` in 1: qualifies `dmem_done` as a cache hit.
- `mem_stall` out 1: freeze PC and all upstream pipeline registers.
- `mw_valid`, `mw_RegWrite`, `mw_MemRead`, `mw_MemWrite`, `mw_halt` out 1 each.
- `mw_writeReg` out RW.
- `mw_ALU_Result`, `mw_read_data`, `mw_read_data_2` out DW each.
- `write_data` out DW: register-file write value.
- `halted` out 1: sticky, processor halted.
- `retire_cnt`, `dreq_cnt`, `dhit_cnt` out CNT_W each: performance counters.

## Operation
- Definitions:
  - `memop = xm_valid & (xm_MemRead | xm_MemWrite)`.
  - `wb_mux` is `mw_read_data` for sel 01, the registered link for sel 10, otherwise `mw_ALU_Result`.
- FSM states: RUN, WAIT, HALTED.
- RUN:
  - `dmem_en = memop`; `dmem_wr = xm_MemWrite`.
  - If `memop & ~dmem_done`: load a bubble into MW, raise `mem_stall`, go to WAIT.
  - Otherwise: capture xm into MW, with `mw_read_data = dmem_rdata` when MemRead, else 0.
  - If the captured `xm_halt & xm_valid` is set, go to HALTED.
- WAIT:
  - `dmem_en` held at 1; address, data and `dmem_wr` held stable by upstream, which is frozen by `mem_stall`.
  - On `dmem_done`: capture into MW, drop `mem_stall`, return to RUN (or go to HALTED if `xm_halt`).
  - Otherwise: keep loading bubbles.
- HALTED:
  - `mem_stall = 1`, `dmem_en = 0`, `halted = 1`.
  - MW loads a bubble every cycle, so `mw_halt` is a single-cycle pulse.
  - Only `rst` exits HALTED.
- Bubble: every `mw_*` control is 0 and `mw_valid = 0`; data fields hold their previous value.
- MW controls are gated by `xm_valid`. An invalid slot always produces a bubble and never requests memory.
- A halt instruction carrying `MemRead`/`MemWrite` performs its access first; the halt is captured together with that access.

## Timing
- MW latency: one cycle for non-memory ops and for memory ops with same-cycle `dmem_done`. With k wait cycles, MW is captured on the edge where `dmem_done` is high.
- `mem_stall` is combinational from `memop`, state and `dmem_done`. It is high in the cycle the miss is seen, in every cycle of WAIT except the `dmem_done` cycle, and continuously in HALTED.
- `write_data` is combinational from the MW registers; there are no additional cycles.
- Reset (asynchronous, any state, including mid-WAIT): state RUN; all `mw_*`, `write_data`, `halted` and counters 0. An outstanding access is abandoned and `dmem_en` drops immediately.
- Counters (saturate at all-ones; they do not wrap):
  - `retire_cnt`: +1 on each edge MW captures a valid instruction with RegWrite, MemWrite or halt.
  - `dreq_cnt`: +1 once per access, on the access's first cycle (RUN with memop).
  - `dhit_cnt`: +1 when that first cycle also has `dmem_done & dmem_hit`.
  - Counters freeze in HALTED.

## Configuration
- `MW_PERF_CNT_EN` defined: the three counters and their logic are present as described.
- `MW_PERF_CNT_EN` undefined: no counter flops; `retire_cnt`, `dreq_cnt` and `dhit_cnt` are tied to 0. All other behaviour is identical.

## Test plan
- ADD to r3, ALU 0x1234, sel 00, `xm_valid` = 1 → next edge: `mw_RegWrite` = 1, `mw_writeReg` = 3, `write_data` = 0x1234, `mem_stall` never asserted, `retire_cnt` = 1.
- LD r5 from addr 0x0040, `dmem_done` and `dmem_hit` in the same cycle, rdata 0xBEEF → one cycle: `mw_MemRead` = 1, `mw_read_data` = 0xBEEF, `write_data` = 0xBEEF, `dreq_cnt` = 1, `dhit_cnt` = 1.
- ST 0x00AA to addr 0x0100, `dmem_done` after 3 wait cycles → `mem_stall` high for 3 cycles, MW shows 3 bubbles, then `mw_MemWrite` = 1, `mw_ALU_Result` = 0x0100; `dreq_cnt` = 1, `dhit_cnt` = 0.
- HALT with `xm_valid` = 1 → `mw_halt` high for exactly 1 cycle; `halted` and `mem_stall` stay 1; further xm inputs produce no `mw_valid` and no `dmem_en`.
- `rst` asserted mid-WAIT → same cycle `dmem_en` = 0 and `mem_stall` = 0; all outputs 0; the first instruction after release behaves as in case 1.
- Build without `MW_PERF_CNT_EN`, rerun cases 1–3 → all counters read 0; `mw_*` outputs identical to the counter-enabled build.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage and MEM/WB pipeline register of the
// 16-bit pipelined processor. It sequences single- and multi-cycle data
// memory accesses, stalls upstream while an access is outstanding, holds
// the sticky halt state and forms the register-file write-back value.
//
// Optional feature macro: MW_PERF_CNT_EN
//   defined   -> retire / data-request / data-hit counters are present
//   undefined -> no counter flops, counter outputs are tied to zero
module mem_wb_stage #(
  parameter int DW    = 16,
  parameter int RW    = 3,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  // EX/MEM latched instruction
  input  logic             xm_valid,
  input  logic             xm_RegWrite,
  input  logic             xm_MemRead,
  input  logic             xm_MemWrite,
  input  logic             xm_halt,
  input  logic [RW-1:0]    xm_writeReg,
  input  logic [1:0]       xm_wb_sel,
  input  logic [DW-1:0]    xm_ALU_Result,
  input  logic [DW-1:0]    xm_read_data_2,
  input  logic [DW-1:0]    xm_link,
  // data memory
  output logic             dmem_en,
  output logic             dmem_wr,
  input  logic [DW-1:0]    dmem_rdata,
  input  logic             dmem_done,
  input  logic             dmem_hit,
  // pipeline control
  output logic             mem_stall,
  // MEM/WB register
  output logic             mw_valid,
  output logic             mw_RegWrite,
  output logic             mw_MemRead,
  output logic             mw_MemWrite,
  output logic             mw_halt,
  output logic [RW-1:0]    mw_writeReg,
  output logic [DW-1:0]    mw_ALU_Result,
  output logic [DW-1:0]    mw_read_data,
  output logic [DW-1:0]    mw_read_data_2,
  output logic [DW-1:0]    write_data,
  output logic             halted,
  // performance counters
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] dreq_cnt,
  output logic [CNT_W-1:0] dhit_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_WAIT   = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  state_e state_q, state_d;

  logic memop_s;
  logic capture_s;
  logic dmem_en_s;
  logic dmem_wr_s;
  logic mem_stall_s;

  // MEM/WB register state
  logic          mw_valid_q,       mw_valid_d;
  logic          mw_RegWrite_q,    mw_RegWrite_d;
  logic          mw_MemRead_q,     mw_MemRead_d;
  logic          mw_MemWrite_q,    mw_MemWrite_d;
  logic          mw_halt_q,        mw_halt_d;
  logic [1:0]    mw_wb_sel_q,      mw_wb_sel_d;
  logic [RW-1:0] mw_writeReg_q,    mw_writeReg_d;
  logic [DW-1:0] mw_ALU_Result_q,  mw_ALU_Result_d;
  logic [DW-1:0] mw_read_data_q,   mw_read_data_d;
  logic [DW-1:0] mw_read_data_2_q, mw_read_data_2_d;
  logic [DW-1:0] mw_link_q,        mw_link_d;
  logic          halted_q,         halted_d;

  assign memop_s = xm_valid & (xm_MemRead | xm_MemWrite);

  // Access sequencing: memory strobes, stall request, MW capture and next state
  always_comb begin
    state_d     = state_q;
    capture_s   = 1'b0;
    dmem_en_s   = 1'b0;
    dmem_wr_s   = 1'b0;
    mem_stall_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        dmem_en_s = memop_s;
        dmem_wr_s = memop_s & xm_MemWrite;
        if (memop_s && !dmem_done) begin
          mem_stall_s = 1'b1;
          state_d     = ST_WAIT;
        end else begin
          capture_s = xm_valid;
          if (xm_valid && xm_halt) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_WAIT: begin
        // upstream is frozen, so the xm fields still describe the access
        dmem_en_s = 1'b1;
        dmem_wr_s = xm_MemWrite;
        if (dmem_done) begin
          capture_s = xm_valid;
          if (xm_valid && xm_halt) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          mem_stall_s = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_HALTED: begin
        mem_stall_s = 1'b1;
        state_d     = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Reset abandons any outstanding access in the same cycle it is raised
  assign dmem_en   = dmem_en_s   & ~rst;
  assign dmem_wr   = dmem_wr_s   & ~rst;
  assign mem_stall = mem_stall_s & ~rst;

  // MW next value: capture the xm slot, otherwise a bubble that keeps data fields
  always_comb begin
    mw_valid_d       = 1'b0;
    mw_RegWrite_d    = 1'b0;
    mw_MemRead_d     = 1'b0;
    mw_MemWrite_d    = 1'b0;
    mw_halt_d        = 1'b0;
    mw_wb_sel_d      = 2'b00;
    mw_writeReg_d    = mw_writeReg_q;
    mw_ALU_Result_d  = mw_ALU_Result_q;
    mw_read_data_d   = mw_read_data_q;
    mw_read_data_2_d = mw_read_data_2_q;
    mw_link_d        = mw_link_q;
    if (capture_s) begin
      mw_valid_d       = 1'b1;
      mw_RegWrite_d    = xm_RegWrite;
      mw_MemRead_d     = xm_MemRead;
      mw_MemWrite_d    = xm_MemWrite;
      mw_halt_d        = xm_halt;
      mw_wb_sel_d      = xm_wb_sel;
      mw_writeReg_d    = xm_writeReg;
      mw_ALU_Result_d  = xm_ALU_Result;
      mw_read_data_2_d = xm_read_data_2;
      mw_link_d        = xm_link;
      if (xm_MemRead) begin
        mw_read_data_d = dmem_rdata;
      end else begin
        mw_read_data_d = {DW{1'b0}};
      end
    end else begin
      mw_valid_d = 1'b0;
    end
  end

  assign halted_d = (state_d == ST_HALTED);

  // State, sticky halt and MEM/WB register flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_RUN;
      halted_q         <= 1'b0;
      mw_valid_q       <= 1'b0;
      mw_RegWrite_q    <= 1'b0;
      mw_MemRead_q     <= 1'b0;
      mw_MemWrite_q    <= 1'b0;
      mw_halt_q        <= 1'b0;
      mw_wb_sel_q      <= 2'b00;
      mw_writeReg_q    <= {RW{1'b0}};
      mw_ALU_Result_q  <= {DW{1'b0}};
      mw_read_data_q   <= {DW{1'b0}};
      mw_read_data_2_q <= {DW{1'b0}};
      mw_link_q        <= {DW{1'b0}};
    end else begin
      state_q          <= state_d;
      halted_q         <= halted_d;
      mw_valid_q       <= mw_valid_d;
      mw_RegWrite_q    <= mw_RegWrite_d;
      mw_MemRead_q     <= mw_MemRead_d;
      mw_MemWrite_q    <= mw_MemWrite_d;
      mw_halt_q        <= mw_halt_d;
      mw_wb_sel_q      <= mw_wb_sel_d;
      mw_writeReg_q    <= mw_writeReg_d;
      mw_ALU_Result_q  <= mw_ALU_Result_d;
      mw_read_data_q   <= mw_read_data_d;
      mw_read_data_2_q <= mw_read_data_2_d;
      mw_link_q        <= mw_link_d;
    end
  end

  assign mw_valid       = mw_valid_q;
  assign mw_RegWrite    = mw_RegWrite_q;
  assign mw_MemRead     = mw_MemRead_q;
  assign mw_MemWrite    = mw_MemWrite_q;
  assign mw_halt        = mw_halt_q;
  assign mw_writeReg    = mw_writeReg_q;
  assign mw_ALU_Result  = mw_ALU_Result_q;
  assign mw_read_data   = mw_read_data_q;
  assign mw_read_data_2 = mw_read_data_2_q;
  assign halted         = halted_q;

  // Write-back source select from the registered MW fields
  always_comb begin
    write_data = mw_ALU_Result_q;
    case (mw_wb_sel_q)
      2'b01:   write_data = mw_read_data_q;
      2'b10:   write_data = mw_link_q;
      default: write_data = mw_ALU_Result_q;
    endcase
  end

`ifdef MW_PERF_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0] dreq_cnt_q,   dreq_cnt_d;
  logic [CNT_W-1:0] dhit_cnt_q,   dhit_cnt_d;
  logic             first_acc_s;

  // Saturating increment: an all-ones counter stays all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // The first cycle of an access is always RUN with a memory op present
  assign first_acc_s = (state_q == ST_RUN) & memop_s;

  // Counter next values; nothing qualifies while halted, so they freeze there
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    dreq_cnt_d   = dreq_cnt_q;
    dhit_cnt_d   = dhit_cnt_q;
    if (capture_s && (xm_RegWrite || xm_MemWrite || xm_halt)) begin
      retire_cnt_d = sat_inc(retire_cnt_q);
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
    if (first_acc_s) begin
      dreq_cnt_d = sat_inc(dreq_cnt_q);
    end else begin
      dreq_cnt_d = dreq_cnt_q;
    end
    if (first_acc_s && dmem_done && dmem_hit) begin
      dhit_cnt_d = sat_inc(dhit_cnt_q);
    end else begin
      dhit_cnt_d = dhit_cnt_q;
    end
  end

  // Performance counter flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_q <= {CNT_W{1'b0}};
      dreq_cnt_q   <= {CNT_W{1'b0}};
      dhit_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      retire_cnt_q <= retire_cnt_d;
      dreq_cnt_q   <= dreq_cnt_d;
      dhit_cnt_q   <= dhit_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign dreq_cnt   = dreq_cnt_q;
  assign dhit_cnt   = dhit_cnt_q;
`else
  // Hit qualifier only feeds the counters; keep it visibly consumed
  logic perf_unused_s;
  assign perf_unused_s = dmem_hit;

  assign retire_cnt = {CNT_W{1'b0}};
  assign dreq_cnt   = {CNT_W{1'b0}};
  assign dhit_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage. Inputs change 1 time unit after a
// rising edge; combinational outputs are checked before the next edge and
// registered outputs 1 time unit after it.
module tb_mem_wb_stage;

  localparam int DW    = 16;
  localparam int RW    = 3;
  localparam int CNT_W = 32;
`ifdef MW_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             xm_valid, xm_RegWrite, xm_MemRead, xm_MemWrite, xm_halt;
  logic [RW-1:0]    xm_writeReg;
  logic [1:0]       xm_wb_sel;
  logic [DW-1:0]    xm_ALU_Result, xm_read_data_2, xm_link;
  logic             dmem_en, dmem_wr;
  logic [DW-1:0]    dmem_rdata;
  logic             dmem_done, dmem_hit;
  logic             mem_stall;
  logic             mw_valid, mw_RegWrite, mw_MemRead, mw_MemWrite, mw_halt;
  logic [RW-1:0]    mw_writeReg;
  logic [DW-1:0]    mw_ALU_Result, mw_read_data, mw_read_data_2, write_data;
  logic             halted;
  logic [CNT_W-1:0] retire_cnt, dreq_cnt, dhit_cnt;

  int n_cmp;
  int n_err;

  mem_wb_stage #(.DW(DW), .RW(RW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .xm_valid(xm_valid), .xm_RegWrite(xm_RegWrite), .xm_MemRead(xm_MemRead),
    .xm_MemWrite(xm_MemWrite), .xm_halt(xm_halt), .xm_writeReg(xm_writeReg),
    .xm_wb_sel(xm_wb_sel), .xm_ALU_Result(xm_ALU_Result),
    .xm_read_data_2(xm_read_data_2), .xm_link(xm_link),
    .dmem_en(dmem_en), .dmem_wr(dmem_wr), .dmem_rdata(dmem_rdata),
    .dmem_done(dmem_done), .dmem_hit(dmem_hit), .mem_stall(mem_stall),
    .mw_valid(mw_valid), .mw_RegWrite(mw_RegWrite), .mw_MemRead(mw_MemRead),
    .mw_MemWrite(mw_MemWrite), .mw_halt(mw_halt), .mw_writeReg(mw_writeReg),
    .mw_ALU_Result(mw_ALU_Result), .mw_read_data(mw_read_data),
    .mw_read_data_2(mw_read_data_2), .write_data(write_data), .halted(halted),
    .retire_cnt(retire_cnt), .dreq_cnt(dreq_cnt), .dhit_cnt(dhit_cnt)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ecnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic mwr,
                       input logic h, input logic [RW-1:0] rd, input logic [1:0] sel,
                       input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                       input logic [DW-1:0] lnk);
    xm_valid = v; xm_RegWrite = rw; xm_MemRead = mr; xm_MemWrite = mwr;
    xm_halt = h; xm_writeReg = rd; xm_wb_sel = sel; xm_ALU_Result = alu;
    xm_read_data_2 = sd; xm_link = lnk;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 16'h0000, 16'h0000, 16'h0000);
    dmem_done = 1'b0; dmem_hit = 1'b0; dmem_rdata = 16'h0000;
  endtask

  // ADD r3 = 0x1234; expects retire count n afterwards
  task automatic run_add(input int n);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 2'b00, 16'h1234, 16'h0000, 16'h0000);
    #1;
    chk("add_stall", 32'(mem_stall), 32'd0);
    chk("add_dmem_en", 32'(dmem_en), 32'd0);
    edge_step();
    chk("add_mw_valid", 32'(mw_valid), 32'd1);
    chk("add_regwrite", 32'(mw_RegWrite), 32'd1);
    chk("add_writereg", 32'(mw_writeReg), 32'd3);
    chk("add_write_data", 32'(write_data), 32'h1234);
    chk("add_retire", retire_cnt, ecnt(n));
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mw_valid", 32'(mw_valid), 32'd0);
    chk("rst_write_data", 32'(write_data), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    rst = 1'b0;
    edge_step();

    // case 1: ALU result write-back
    run_add(1);

    // JAL r7: link write-back
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 2'b10, 16'h5555, 16'h0000, 16'h0022);
    edge_step();
    chk("jal_write_data", 32'(write_data), 32'h0022);
    chk("jal_writereg", 32'(mw_writeReg), 32'd7);
    chk("jal_retire", retire_cnt, ecnt(2));
    idle();

    // case 2: LD r5 with same-cycle hit
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 2'b01, 16'h0040, 16'h0000, 16'h0000);
    dmem_done = 1'b1; dmem_hit = 1'b1; dmem_rdata = 16'hBEEF;
    #1;
    chk("ld_dmem_en", 32'(dmem_en), 32'd1);
    chk("ld_dmem_wr", 32'(dmem_wr), 32'd0);
    chk("ld_stall", 32'(mem_stall), 32'd0);
    edge_step();
    chk("ld_memread", 32'(mw_MemRead), 32'd1);
    chk("ld_read_data", 32'(mw_read_data), 32'hBEEF);
    chk("ld_write_data", 32'(write_data), 32'hBEEF);
    chk("ld_dreq", dreq_cnt, ecnt(1));
    chk("ld_dhit", dhit_cnt, ecnt(1));
    idle();

    // case 3: ST 0x00AA to 0x0100 with three wait cycles
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'b00, 16'h0100, 16'h00AA, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_wait_stall", 32'(mem_stall), 32'd1);
      chk("st_wait_en", 32'(dmem_en), 32'd1);
      chk("st_wait_wr", 32'(dmem_wr), 32'd1);
      edge_step();
      chk("st_bubble", 32'(mw_valid), 32'd0);
    end
    dmem_done = 1'b1;
    #1;
    chk("st_done_stall", 32'(mem_stall), 32'd0);
    edge_step();
    chk("st_memwrite", 32'(mw_MemWrite), 32'd1);
    chk("st_alu", 32'(mw_ALU_Result), 32'h0100);
    chk("st_data2", 32'(mw_read_data_2), 32'h00AA);
    chk("st_read_data", 32'(mw_read_data), 32'h0000);
    chk("st_dreq", dreq_cnt, ecnt(2));
    chk("st_dhit", dhit_cnt, ecnt(1));
    chk("st_retire", retire_cnt, ecnt(4));
    idle();

    // invalid slot carrying MemRead: bubble, no request
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 2'b01, 16'h0080, 16'h0000, 16'h0000);
    #1;
    chk("inv_dmem_en", 32'(dmem_en), 32'd0);
    edge_step();
    chk("inv_mw_valid", 32'(mw_valid), 32'd0);
    chk("inv_dreq", dreq_cnt, ecnt(2));
    idle();

    // reset raised while a load is waiting
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 2'b01, 16'h0060, 16'h0000, 16'h0000);
    edge_step();
    chk("rw_stall_before", 32'(mem_stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_dmem_en", 32'(dmem_en), 32'd0);
    chk("rw_stall", 32'(mem_stall), 32'd0);
    chk("rw_write_data", 32'(write_data), 32'd0);
    chk("rw_dreq", dreq_cnt, 32'd0);
    edge_step();
    idle();
    rst = 1'b0;
    edge_step();
    run_add(1);

    // HALT: single-cycle mw_halt, then frozen
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00, 16'h0000, 16'h0000, 16'h0000);
    edge_step();
    chk("halt_mw_halt", 32'(mw_halt), 32'd1);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_stall", 32'(mem_stall), 32'd1);
    chk("halt_retire", retire_cnt, ecnt(2));
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 2'b01, 16'h0010, 16'h0000, 16'h0000);
    dmem_done = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("hlt_dmem_en", 32'(dmem_en), 32'd0);
      edge_step();
      chk("hlt_mw_halt", 32'(mw_halt), 32'd0);
      chk("hlt_mw_valid", 32'(mw_valid), 32'd0);
      chk("hlt_halted", 32'(halted), 32'd1);
      chk("hlt_stall", 32'(mem_stall), 32'd1);
      chk("hlt_retire", retire_cnt, ecnt(2));
      chk("hlt_dreq", dreq_cnt, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
